univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register. It is the next generation of the team's 4-bit SISO/SIPO/PISO/PIPO registers, all four folded into one WIDTH-bit block.
- Runtime mode selects hold, shift left/right, rotate, arithmetic shift, parallel load and clear.
- A shift counter flags each completed WIDTH-bit word, for serializer/deserializer framing in datapath and serial-link logic.

Parameters:
- WIDTH, 8: register width in bits; legal range 2..64.
- RESET_VAL, 0: WIDTH-bit value loaded into the register on reset.
- CW, $clog2(WIDTH): bit_cnt width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  operation enable; when low, the register holds regardless of mode.
- mode  input  3  operation select (encoding below).
- p_in  input  WIDTH  parallel load data.
- s_in_r  input  1  serial bit entering at bit 0 on shift left.
- s_in_l  input  1  serial bit entering at bit WIDTH-1 on logical shift right.
- p_out  output  WIDTH  register contents (direct register output).
- s_out_msb  output  1  equal to p_out[WIDTH-1], combinational from the register.
- s_out_lsb  output  1  equal to p_out[0], combinational from the register.
- bit_cnt  output  CW  number of shift/rotate ops since the last load, clear or wrap.
- word_done  output  1  registered one-cycle pulse marking a completed word.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately, overrides everything):
  - p_out = RESET_VAL
  - bit_cnt = 0
  - word_done = 0
- Reset release is synchronous to the next rising clk edge; the first operation occurs at the first edge with reset_n high.
- All updates occur on the rising clk edge and only when en=1. With en=0, p_out and bit_cnt hold and word_done = 0.
- Mode encoding (R = p_out before the edge):
  - 000 HOLD: R unchanged.
  - 001 SHL: {R[WIDTH-2:0], s_in_r}.
  - 010 SHR: {s_in_l, R[WIDTH-1:1]}.
  - 011 LOAD: p_in.
  - 100 ROTL: {R[WIDTH-2:0], R[WIDTH-1]}.
  - 101 ROTR: {R[0], R[WIDTH-1:1]}.
  - 110 ASR: {R[WIDTH-1], R[WIDTH-1:1]}; sign bit replicated, s_in_l ignored.
  - 111 CLEAR: all zeros.
- Shift ops are SHL, SHR, ROTL, ROTR and ASR. Each shift op with en=1 advances bit_cnt by 1.
- Counter wrap: when bit_cnt == WIDTH-1 and a shift op occurs, bit_cnt wraps to 0 and word_done = 1 in the following cycle for exactly one cycle. word_done is a registered pulse: it is high the cycle after the WIDTH-th shift.
- LOAD and CLEAR set bit_cnt = 0 and word_done = 0 on that edge.
- HOLD leaves bit_cnt unchanged and drives word_done = 0.
- Back-to-back words: continuous shifting gives a word_done pulse every WIDTH cycles with no gap cycle.
- Serial-to-parallel use: shift WIDTH bits with SHL; p_out holds the word in the cycle word_done is high.
- Parallel-to-serial use: LOAD, then WIDTH SHL ops; s_out_msb presents the MSB first. word_done marks the end of the word.
- Mode changes mid-word are legal. The count continues across any mix of shift ops.
- Reset asserted mid-word aborts the word: bit_cnt = 0, no word_done pulse.
- Undefined states: none; all 8 mode codes are defined, and p_out is never X after reset.

Test Plan:
- Reset and hold (WIDTH=8, RESET_VAL=8'hA5): assert reset_n low between edges -> p_out=8'hA5, bit_cnt=0, word_done=0 immediately; then en=1, mode=HOLD for 3 cycles -> p_out stays 8'hA5.
- Load and rotate: LOAD p_in=8'h81, then ROTL -> p_out=8'h03; then ROTR twice -> 8'hC0; bit_cnt=3.
- Arithmetic and logical shift right: LOAD 8'h90, ASR -> 8'hC8; then SHR with s_in_l=0 -> 8'h64; bit_cnt=2.
- SIPO framing: LOAD 0, then 8 SHL with s_in_r bits 1,0,1,1,0,0,1,0 -> p_out=8'hB2; word_done=1 in the cycle after the 8th shift; bit_cnt=0.
- PISO and back-to-back: LOAD 8'h6C, then 16 continuous SHL with s_in_r=0 -> s_out_msb sequence 0,1,1,0,1,1,0,0 then zeros; word_done pulses after shifts 8 and 16 only.
- Enable gating and mid-word abort: after 5 SHL, en=0 for 2 cycles -> p_out and bit_cnt frozen at bit_cnt=5; then assert reset_n low -> p_out=RESET_VAL, bit_cnt=0, no word_done pulse; also CLEAR at bit_cnt=7 -> p_out=0, bit_cnt=0, no pulse.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register.
//
// This block combines the SISO, SIPO, PISO and PIPO register styles in one
// register. The mode input selects the operation on each enabled clock edge:
// hold, logical shift left or right, rotate left or right, arithmetic shift
// right, parallel load or clear.
//
// A shift counter counts the shift and rotate ops that have happened since
// the last load, clear or wrap. It emits a one-cycle word_done pulse after
// every WIDTH-th shift, which framing logic in serializers and deserializers
// can use.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (p_out=RESET_VAL, counter cleared)
//   en         operation enable; low freezes p_out and bit_cnt
//   mode       operation select (see mode_e)
//   p_in       parallel load data
//   s_in_r     serial bit entering at bit 0 on shift left
//   s_in_l     serial bit entering at bit WIDTH-1 on logical shift right
//   p_out      register contents
//   s_out_msb  p_out[WIDTH-1]
//   s_out_lsb  p_out[0]
//   bit_cnt    shift ops since the last load, clear or wrap
//   word_done  registered pulse, high the cycle after the WIDTH-th shift
module univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] p_in,
  input  logic             s_in_r,
  input  logic             s_in_l,
  output logic [WIDTH-1:0] p_out,
  output logic             s_out_msb,
  output logic             s_out_lsb,
  output logic [CW-1:0]    bit_cnt,
  output logic             word_done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] reg_nxt;
  logic             is_shift;
  logic             is_restart;

  // Arithmetic shift right done as a signed shift so the sign bit replicates.
  function automatic logic [WIDTH-1:0] asr1(input logic [WIDTH-1:0] val);
    logic signed [WIDTH-1:0] sval;
    sval = val;
    return sval >>> 1;
  endfunction

  always_comb begin
    reg_nxt    = p_out;
    is_shift   = 1'b0;
    is_restart = 1'b0;
    case (mode)
      MODE_HOLD:  reg_nxt = p_out;
      MODE_SHL: begin
        reg_nxt  = {p_out[WIDTH-2:0], s_in_r};
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        reg_nxt  = {s_in_l, p_out[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_LOAD: begin
        reg_nxt    = p_in;
        is_restart = 1'b1;
      end
      MODE_ROTL: begin
        reg_nxt  = {p_out[WIDTH-2:0], p_out[WIDTH-1]};
        is_shift = 1'b1;
      end
      MODE_ROTR: begin
        reg_nxt  = {p_out[0], p_out[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_ASR: begin
        reg_nxt  = asr1(p_out);
        is_shift = 1'b1;
      end
      MODE_CLEAR: begin
        reg_nxt    = '0;
        is_restart = 1'b1;
      end
      default: reg_nxt = p_out;
    endcase
  end

  // Register and framing counter. word_done defaults low so it can only be a
  // single-cycle pulse. A wrapping shift re-arms it on back-to-back words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_out     <= RESET_VAL;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (en) begin
        p_out <= reg_nxt;
        if (is_restart) begin
          bit_cnt <= '0;
        end else if (is_shift) begin
          if (bit_cnt == CNT_MAX) begin
            bit_cnt   <= '0;
            word_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end
    end
  end

  assign s_out_msb = p_out[WIDTH-1];
  assign s_out_lsb = p_out[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int          W  = 8;
  localparam logic [7:0]  RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] p_in;
  logic       s_in_r;
  logic       s_in_l;
  logic [7:0] p_out;
  logic       s_out_msb;
  logic       s_out_lsb;
  logic [2:0] bit_cnt;
  logic       word_done;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .mode      (mode),
    .p_in      (p_in),
    .s_in_r    (s_in_r),
    .s_in_l    (s_in_l),
    .p_out     (p_out),
    .s_out_msb (s_out_msb),
    .s_out_lsb (s_out_lsb),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    p;
    int    cnt;
    bit    wd;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: register value as an integer 0..255 and the
  // number of shifts since the last load, clear or completed word.
  int m_r;
  int m_cnt;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after every rising edge, compare outputs against the oldest
  // expectation issued by the stimulus process.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".p_out"}, int'(p_out), e.p);
        chk({e.tag, ".bit_cnt"}, int'(bit_cnt), e.cnt);
        chk({e.tag, ".word_done"}, int'(word_done), int'(e.wd));
        chk({e.tag, ".serial"}, int'({s_out_msb, s_out_lsb}),
            ((e.p / 128) * 2) + (e.p % 2));
      end
    end
  end

  task automatic op(input string tag, input logic e, input logic [2:0] md,
                    input logic [7:0] pi, input logic sr, input logic sl);
    bit shifted;
    bit wd;
    @(negedge clk);
    en = e; mode = md; p_in = pi; s_in_r = sr; s_in_l = sl;
    shifted = 1'b0;
    wd      = 1'b0;
    if (e) begin
      case (md)
        3'd1: begin m_r = (m_r * 2 + int'(sr)) % 256;          shifted = 1'b1; end
        3'd2: begin m_r = m_r / 2 + int'(sl) * 128;            shifted = 1'b1; end
        3'd3: begin m_r = int'(pi); m_cnt = 0;                              end
        3'd4: begin m_r = (m_r * 2) % 256 + m_r / 128;         shifted = 1'b1; end
        3'd5: begin m_r = m_r / 2 + (m_r % 2) * 128;           shifted = 1'b1; end
        3'd6: begin m_r = m_r / 2 + (m_r / 128) * 128;         shifted = 1'b1; end
        3'd7: begin m_r = 0; m_cnt = 0;                                     end
        default: ;
      endcase
      if (shifted) begin
        m_cnt++;
        if (m_cnt == W) begin
          m_cnt = 0;
          wd    = 1'b1;
        end
      end
    end
    q.push_back('{m_r, m_cnt, wd, tag});
  endtask

  // Asynchronous reset between edges, checked immediately; released on a
  // falling edge so the next rising edge is the first live one.
  task automatic do_reset(input string tag);
    @(negedge clk);
    en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk({tag, ".rst_p_out"}, int'(p_out), int'(RV));
    chk({tag, ".rst_bit_cnt"}, int'(bit_cnt), 0);
    chk({tag, ".rst_word_done"}, int'(word_done), 0);
    m_r   = int'(RV);
    m_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] sipo_bits;
    int         r;
    logic [2:0] md;
    reset_n = 1'b1; en = 1'b0; mode = 3'd0; p_in = 8'h00; s_in_r = 1'b0; s_in_l = 1'b0;
    m_r = 0; m_cnt = 0;
    #7;

    // Reset and hold
    do_reset("reset");
    repeat (3) op("hold", 1'b1, 3'd0, 8'hFF, 1'b1, 1'b1);

    // Load and rotate: 81 -> ROTL 03 -> ROTR 81 -> ROTR C0, bit_cnt 3
    op("load81", 1'b1, 3'd3, 8'h81, 1'b0, 1'b0);
    op("rotl",   1'b1, 3'd4, 8'h00, 1'b1, 1'b1);
    op("rotr1",  1'b1, 3'd5, 8'h00, 1'b0, 1'b1);
    op("rotr2",  1'b1, 3'd5, 8'h00, 1'b0, 1'b1);

    // Arithmetic then logical shift right: 90 -> C8 -> 64
    op("load90", 1'b1, 3'd3, 8'h90, 1'b0, 1'b0);
    op("asr",    1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
    op("shr",    1'b1, 3'd2, 8'h00, 1'b1, 1'b0);

    // SIPO framing: bits 1,0,1,1,0,0,1,0 -> B2 with word_done
    op("load0", 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    sipo_bits = 8'hB2;
    for (int i = 7; i >= 0; i--) op("sipo", 1'b1, 3'd1, 8'h00, sipo_bits[i], 1'b0);
    op("sipo_after", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);

    // PISO with back-to-back words
    op("load6c", 1'b1, 3'd3, 8'h6C, 1'b0, 1'b0);
    repeat (16) op("piso", 1'b1, 3'd1, 8'h00, 1'b0, 1'b0);

    // Enable gating, then mid-word reset abort
    op("load_en", 1'b1, 3'd3, 8'h3C, 1'b0, 1'b0);
    repeat (5) op("shl5", 1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
    repeat (2) op("en_off", 1'b0, 3'd1, 8'h00, 1'b1, 1'b1);
    do_reset("abort");
    op("post_abort", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);

    // CLEAR at bit_cnt 7 gives no pulse
    repeat (7) op("shl7", 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    op("clear", 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
    op("post_clear", 1'b1, 3'd1, 8'h00, 1'b1, 1'b0);

    // Randomized traffic, shift-heavy so words complete often
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 15);
      if (r < 11) begin
        case ($urandom_range(0, 4))
          0: md = 3'd1;
          1: md = 3'd2;
          2: md = 3'd4;
          3: md = 3'd5;
          default: md = 3'd6;
        endcase
      end else begin
        case ($urandom_range(0, 2))
          0: md = 3'd0;
          1: md = 3'd3;
          default: md = 3'd7;
        endcase
      end
      if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
      op("rand", ($urandom_range(0, 9) != 0), md, 8'($urandom),
         1'($urandom), 1'($urandom));
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
